// File: rtl/sigmoid8_pla_pkg.sv
// Shared Q-format constants, knot table and interpolation helper for the
// sigmoid8_pla activation unit.
package sigmoid8_pla_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int ONE_Q16 = 65536;
  localparam int SAT_ABS = 2048;

  // Unsigned Q0.16 knot; 17 bits so that 1.0 (65536) is representable.
  typedef logic [16:0] knot_t;

  // sigmoid(k) for k = 0..8, scaled by 65536.
  function automatic knot_t knot_at(input logic [3:0] idx);
    knot_t k;
    case (idx)
      4'd0:    k = 17'd32768;
      4'd1:    k = 17'd47911;
      4'd2:    k = 17'd57724;
      4'd3:    k = 17'd62428;
      4'd4:    k = 17'd64357;
      4'd5:    k = 17'd65097;
      4'd6:    k = 17'd65374;
      4'd7:    k = 17'd65476;
      4'd8:    k = 17'd65514;
      default: k = 17'(ONE_Q16);
    endcase
    return k;
  endfunction

  // Linear interpolation between two knots; the product is truncated.
  function automatic knot_t interp(input knot_t lo, input knot_t hi,
                                   input logic [FRAC_W-1:0] frac);
    logic [24:0] prod;
    prod = 25'(hi - lo) * 25'(frac);
    return lo + prod[24:8];
  endfunction

endpackage

// File: rtl/sigmoid8_pla_lut.sv
// Combinational knot lookup: returns the knots bracketing segment seg.
module sigmoid8_pla_lut
  import sigmoid8_pla_pkg::*;
(
  input  logic [2:0] seg,
  output knot_t      k_lo,
  output knot_t      k_hi
);

  knot_t knots [0:8];

  for (genvar gi = 0; gi <= 8; gi++) begin : g_knots
    assign knots[gi] = knot_at(4'(gi));
  end

  assign k_lo = knots[{1'b0, seg}];
  assign k_hi = knots[{1'b0, seg} + 4'd1];

endmodule

// File: rtl/sigmoid8_pla.sv
// Two-stage piecewise-linear sigmoid, signed Q8.8 in, unsigned Q8.8 out.
// Build option: define SIGMOID8_PLA_ROUND_EN for round-half-up output.
module sigmoid8_pla
  import sigmoid8_pla_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] y_out,
  output logic              valid_out
);

  function automatic logic [DATA_W-1:0] to_q88(input knot_t q);
    logic [17:0] qr;
`ifdef SIGMOID8_PLA_ROUND_EN
    qr = {1'b0, q} + 18'd128;
`else
    qr = {1'b0, q};
`endif
    return {6'd0, qr[17:8]};
  endfunction

  // Stage 1: magnitude split into saturation flag, segment and fraction.
  logic [DATA_W-1:0] abs_x;
  logic              sat_next;
  logic              sign_reg, sat_reg, v1_reg;
  logic [2:0]        seg_reg;
  logic [FRAC_W-1:0] frac_reg;

  assign abs_x    = x_in[DATA_W-1] ? (~x_in + 16'd1) : x_in;
  assign sat_next = (abs_x >= 16'(SAT_ABS));

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      sign_reg <= 1'b0;
      sat_reg  <= 1'b0;
      seg_reg  <= '0;
      frac_reg <= '0;
    end else begin
      v1_reg <= valid_in;
      if (valid_in) begin
        sign_reg <= x_in[DATA_W-1];
        sat_reg  <= sat_next;
        seg_reg  <= abs_x[10:8];
        frac_reg <= abs_x[FRAC_W-1:0];
      end
    end
  end

  // Stage 2: interpolate, mirror for negative inputs, reduce to Q8.8.
  knot_t             k_lo, k_hi, pos, q;
  logic [DATA_W-1:0] y_next;
  logic [DATA_W-1:0] y_reg;
  logic              valid_reg;

  sigmoid8_pla_lut u_lut (
    .seg  (seg_reg),
    .k_lo (k_lo),
    .k_hi (k_hi)
  );

  assign pos    = sat_reg ? 17'(ONE_Q16) : interp(k_lo, k_hi, frac_reg);
  assign q      = sign_reg ? (17'(ONE_Q16) - pos) : pos;
  assign y_next = to_q88(q);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      y_reg     <= '0;
    end else begin
      valid_reg <= v1_reg;
      if (v1_reg) y_reg <= y_next;
    end
  end

  assign y_out     = y_reg;
  assign valid_out = valid_reg;

endmodule

// File: tb/tb_sigmoid8_pla.sv
// Self-checking bench for sigmoid8_pla: directed cases, random stream and a
// full input sweep against an arithmetic reference model.
module tb_sigmoid8_pla;

  logic        clk;
  logic        rst;
  logic [15:0] x_in;
  logic        valid_in;
  logic [15:0] y_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  sigmoid8_pla dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .valid_in  (valid_in),
    .y_out     (y_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [15:0] x;
    int          y;
  } exp_t;

  exp_t expq[$];
  int   last_y;
  int   obs [0:65535];
  int   knot [0:8] = '{32768, 47911, 57724, 62428, 64357, 65097, 65374, 65476, 65514};

  // Sigmoid model built straight from the knot table with integer arithmetic.
  function automatic int ref_y(input logic [15:0] x);
    int xs, a, seg, frac, pos, q;
    xs = int'($signed(x));
    a  = (xs < 0) ? -xs : xs;
    if (a >= 2048) pos = 65536;
    else begin
      seg  = a / 256;
      frac = a % 256;
      pos  = knot[seg] + ((knot[seg+1] - knot[seg]) * frac) / 256;
    end
    q = (xs < 0) ? 65536 - pos : pos;
`ifdef SIGMOID8_PLA_ROUND_EN
    return (q + 128) / 256;
`else
    return q / 256;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Drive one cycle; the sample driven one call earlier is now at the output.
  task automatic step(input bit v, input logic [15:0] x);
    exp_t e, o;
    valid_in = v;
    x_in     = x;
    e.v = v; e.x = x; e.y = ref_y(x);
    expq.push_back(e);
    @(posedge clk); #1;
    o = expq.pop_front();
    if (o.v) last_y = o.y;
    chk("valid_out", valid_out, 32'(o.v));
    chk("y_out", y_out, last_y);
    if (o.v) obs[int'(o.x)] = int'(y_out);
  endtask

  task automatic do_reset(input int n);
    exp_t d;
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_y_out", y_out, 0);
      chk("rst_valid_out", valid_out, 0);
    end
    rst      = 1'b0;
    valid_in = 1'b0;
    expq.delete();
    d.v = 0; d.x = '0; d.y = 0;
    expq.push_back(d);
    last_y = 0;
  endtask

  logic [15:0] stream_x [0:5];
  int          stream_y [0:5];
  logic [15:0] sat_x    [0:3];
  int          sat_y    [0:3];
  int          sum;

  initial begin
    rst = 1'b1; valid_in = 1'b0; x_in = '0;
    stream_x = '{16'hFA00, 16'hFB80, 16'hFD00, 16'h0000, 16'h0300, 16'h0600};
`ifdef SIGMOID8_PLA_ROUND_EN
    stream_y = '{1, 3, 12, 128, 244, 255};
`else
    stream_y = '{0, 3, 12, 128, 243, 255};
`endif
    sat_x = '{16'h0800, 16'h7FFF, 16'hF800, 16'h8000};
    sat_y = '{256, 256, 0, 0};

    do_reset(2);
    repeat (3) step(0, 16'h0100);

    // Back-to-back stream with known results.
    for (int i = 0; i < 7; i++) begin
      step(i < 6, (i < 6) ? stream_x[i] : 16'h0);
      if (i >= 1) chk("stream_const", y_out, stream_y[i-1]);
    end

    // Saturation extremes.
    for (int i = 0; i < 5; i++) begin
      step(i < 4, (i < 4) ? sat_x[i] : 16'h0);
      if (i >= 1) chk("sat_const", y_out, sat_y[i-1]);
    end

    // Valid gap: output holds across the idle cycle.
    step(1, 16'h0100);
    step(0, 16'h0000);
    chk("gap_first", y_out, 187);
    step(1, 16'hFF00);
    chk("gap_hold", y_out, 187);
    chk("gap_hold_valid", valid_out, 0);
    step(0, 16'h0000);
`ifdef SIGMOID8_PLA_ROUND_EN
    chk("gap_last", y_out, 69);
`else
    chk("gap_last", y_out, 68);
`endif

    // Reset with two samples in flight: neither may emerge.
    step(1, 16'h0300);
    valid_in = 1'b1; x_in = 16'h0600;
    do_reset(1);
    repeat (2) step(0, 16'h0000);
    step(1, 16'h0300);
    step(0, 16'h0000);

    // Random stream with random gaps.
    repeat (400) begin
      if ($urandom_range(0, 1) == 1) step($urandom_range(0, 3) != 0, 16'($urandom));
      else step($urandom_range(0, 3) != 0, 16'($urandom_range(0, 4800) - 2400));
    end

    // Exhaustive sweep, then shape checks on the collected outputs.
    for (int i = 0; i < 65536; i++) step(1, 16'(i));
    step(0, 16'h0000);
    for (int i = -32768; i < 32767; i++)
      chk("monotonic", 32'(obs[int'(16'(i+1))] >= obs[int'(16'(i))]), 1);
    for (int i = 1; i < 32768; i++) begin
      sum = obs[i] + obs[int'(16'(-i))];
      chk("symmetry", 32'(sum >= 255 && sum <= 257), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
